// File: rtl/exec_writeback_unit.sv
// Multi-cycle execute/writeback sequencer driving a 4-entry x 4-bit register file.
// Each instruction walks IDLE -> READ -> EXEC -> WB, so one instruction completes every 4 cycles.
module exec_writeback_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic [1:0] rs,
    output logic [1:0] rt,
    input  logic [3:0] crs,
    input  logic [3:0] crt,
    output logic [1:0] rw,
    output logic [3:0] dw,
    output logic       rwe,
    output logic       zero,
    output logic       carry,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    state_t     state_reg;
    logic [1:0] op_reg;
    logic [1:0] rd_reg;
    logic [1:0] rs_reg;
    logic [1:0] rt_reg;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic [1:0] rw_reg;
    logic [3:0] dw_reg;
    logic       rwe_reg;
    logic       zero_reg;
    logic       carry_reg;
    logic       busy_reg;

    logic       accept;
    logic [4:0] sum_next;
    logic [4:0] diff_next;
    logic [3:0] result_next;
    logic       carry_next;

    assign instr_ready = (state_reg == IDLE);
    assign accept      = instr_valid && instr_ready;

    // Both the sum and the difference are extended by one bit so bit 4
    // directly yields the ADD carry-out and the unsigned SUB borrow.
    always_comb begin
        sum_next    = {1'b0, a_reg} + {1'b0, b_reg};
        diff_next   = {1'b0, a_reg} - {1'b0, b_reg};
        result_next = 4'b0000;
        carry_next  = 1'b0;
        case (op_reg)
            OP_ADD: begin
                result_next = sum_next[3:0];
                carry_next  = sum_next[4];
            end
            OP_SUB: begin
                result_next = diff_next[3:0];
                carry_next  = diff_next[4];
            end
            OP_AND: begin
                result_next = a_reg & b_reg;
                carry_next  = 1'b0;
            end
            OP_LDI: begin
                // The immediate travels in the ra/rb fields, which live on in rs/rt.
                result_next = {rs_reg, rt_reg};
                carry_next  = 1'b0;
            end
            default: begin
                result_next = 4'b0000;
                carry_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= 2'b00;
            rd_reg    <= 2'b00;
            rs_reg    <= 2'b00;
            rt_reg    <= 2'b00;
            a_reg     <= 4'b0000;
            b_reg     <= 4'b0000;
            rw_reg    <= 2'b00;
            dw_reg    <= 4'b0000;
            rwe_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            carry_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            rwe_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= instr[7:6];
                        rd_reg    <= instr[5:4];
                        rs_reg    <= instr[3:2];
                        rt_reg    <= instr[1:0];
                        busy_reg  <= 1'b1;
                        state_reg <= READ;
                    end
                end
                READ: begin
                    a_reg     <= crs;
                    b_reg     <= crt;
                    state_reg <= EXEC;
                end
                EXEC: begin
                    dw_reg    <= result_next;
                    zero_reg  <= (result_next == 4'b0000);
                    carry_reg <= carry_next;
                    rw_reg    <= rd_reg;
                    rwe_reg   <= 1'b1;
                    state_reg <= WB;
                end
                WB: begin
                    // The register file commits on this edge, so the next READ sees it.
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rs    = rs_reg;
    assign rt    = rt_reg;
    assign rw    = rw_reg;
    assign dw    = dw_reg;
    assign rwe   = rwe_reg;
    assign zero  = zero_reg;
    assign carry = carry_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_exec_writeback_unit.sv
// Directed bench for exec_writeback_unit with a behavioural 4x4 register file attached.
// Expected results are hand-computed per instruction sequence.
module tb_exec_writeback_unit;

    logic       clk;
    logic       rst;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [3:0] crs;
    logic [3:0] crt;
    logic [1:0] rw;
    logic [3:0] dw;
    logic       rwe;
    logic       zero;
    logic       carry;
    logic       busy;

    int tests_run;
    int tests_failed;

    logic [3:0] regs [4];

    // Result snapshot taken by exec_instr during the WB cycle.
    logic       wb_seen;
    int         wb_lat;
    logic [1:0] wb_rw;
    logic [3:0] wb_dw;
    logic       wb_zero;
    logic       wb_carry;
    logic       wb_after;
    logic       busy_in_read;
    logic       ready_in_read;

    exec_writeback_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rs          (rs),
        .rt          (rt),
        .crs         (crs),
        .crt         (crt),
        .rw          (rw),
        .dw          (dw),
        .rwe         (rwe),
        .zero        (zero),
        .carry       (carry),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign crs = regs[rs];
    assign crt = regs[rt];

    always @(posedge clk) begin
        if (rwe) regs[rw] <= dw;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one instruction from IDLE and follow it to the end of WB.
    task automatic exec_instr(input logic [7:0] ins, input bit toggle);
        int w;
        wb_seen  = 1'b0;
        wb_lat   = 0;
        wb_after = 1'b1;
        w = 0;
        while (!instr_ready && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid   = 1'b0;
        busy_in_read  = busy;
        ready_in_read = instr_ready;
        for (int c = 1; c <= 8; c++) begin
            if (rwe) begin
                wb_seen     = 1'b1;
                wb_lat      = c;
                wb_rw       = rw;
                wb_dw       = dw;
                wb_zero     = zero;
                wb_carry    = carry;
                instr_valid = 1'b0;
                break;
            end
            if (toggle) begin
                instr       = 8'($urandom);
                instr_valid = 1'b1;
            end
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        if (wb_seen) begin
            @(posedge clk); #1;
            wb_after = rwe;
        end
        $display("[TB] instr=%b seen=%0d lat=%0d rw=%b dw=%b zero=%b carry=%b",
                 ins, wb_seen, wb_lat, wb_rw, wb_dw, wb_zero, wb_carry);
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        instr       = 8'b11_01_0101;
        instr_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst         = 1'b0;
        instr_valid = 1'b0;
        tests_run++;
        if (instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 1", instr_ready);
        end
        tests_run++;
        if ({rs, rt, rw, dw, rwe, zero, carry, busy} !== 14'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rs=%b rt=%b rw=%b dw=%b rwe=%b z=%b c=%b busy=%b want all 0",
                     rs, rt, rw, dw, rwe, zero, carry, busy);
        end
        $display("[TB] reset released ready=%b busy=%b", instr_ready, busy);
    endtask

    task automatic test_ldi;
        exec_instr(8'b11_01_0101, 1'b0);
        tests_run++;
        if (wb_seen !== 1'b1 || wb_lat != 3) begin
            tests_failed++;
            $display("FAIL ldi_latency: got seen=%b cycle=%0d want seen=1 cycle=3", wb_seen, wb_lat);
        end
        tests_run++;
        if ({wb_rw, wb_dw, wb_zero, wb_carry} !== {2'b01, 4'b0101, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL ldi_result: got rw=%b dw=%b z=%b c=%b want rw=01 dw=0101 z=0 c=0",
                     wb_rw, wb_dw, wb_zero, wb_carry);
        end
        tests_run++;
        if (busy_in_read !== 1'b1 || ready_in_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL ldi_busy_read: got busy=%b ready=%b want busy=1 ready=0", busy_in_read, ready_in_read);
        end
        tests_run++;
        if (wb_after !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ldi_rwe_pulse: got rwe=%b busy=%b ready=%b after WB want 0 0 1", wb_after, busy, instr_ready);
        end
        tests_run++;
        if (dw !== 4'b0101 || rw !== 2'b01) begin
            tests_failed++;
            $display("FAIL ldi_hold: got rw=%b dw=%b after WB want rw=01 dw=0101", rw, dw);
        end
    endtask

    task automatic test_add_carry;
        exec_instr(8'b11_01_1001, 1'b0);
        exec_instr(8'b11_10_1001, 1'b0);
        exec_instr(8'b00_11_01_10, 1'b0);
        tests_run++;
        if ({wb_seen, wb_rw, wb_dw, wb_carry, wb_zero} !== {1'b1, 2'b11, 4'b0010, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_carry: got seen=%b rw=%b dw=%b c=%b z=%b want 1 11 0010 1 0",
                     wb_seen, wb_rw, wb_dw, wb_carry, wb_zero);
        end
        tests_run++;
        if (regs[3] !== 4'b0010) begin
            tests_failed++;
            $display("FAIL add_regfile: got r3=%b want 0010", regs[3]);
        end
    endtask

    task automatic test_sub;
        exec_instr(8'b11_01_0101, 1'b0);
        exec_instr(8'b01_00_01_01, 1'b0);
        tests_run++;
        if ({wb_seen, wb_dw, wb_zero, wb_carry} !== {1'b1, 4'b0000, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL sub_zero: got seen=%b dw=%b z=%b c=%b want 1 0000 1 0", wb_seen, wb_dw, wb_zero, wb_carry);
        end
        exec_instr(8'b11_10_0011, 1'b0);
        exec_instr(8'b01_00_10_01, 1'b0);
        tests_run++;
        if ({wb_seen, wb_dw, wb_zero, wb_carry} !== {1'b1, 4'b1110, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL sub_borrow: got seen=%b dw=%b z=%b c=%b want 1 1110 0 1", wb_seen, wb_dw, wb_zero, wb_carry);
        end
        tests_run++;
        if (zero !== 1'b0 || carry !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_flag_hold: got z=%b c=%b want 0 1", zero, carry);
        end
    endtask

    task automatic test_reset_in_exec;
        logic saw_rwe;
        saw_rwe     = 1'b0;
        instr       = 8'b11_11_1111;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b1 || instr_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_in_exec: got busy=%b ready=%b before reset want 1 0", busy, instr_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if ({rs, rt, rw, dw, rwe, zero, carry, busy} !== 14'b0 || instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_outputs: got rs=%b rt=%b rw=%b dw=%b rwe=%b z=%b c=%b busy=%b ready=%b want zeros and ready=1",
                     rs, rt, rw, dw, rwe, zero, carry, busy, instr_ready);
        end
        for (int c = 0; c < 5; c++) begin
            if (rwe) saw_rwe = 1'b1;
            @(posedge clk); #1;
        end
        tests_run++;
        if (saw_rwe !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_rwe: got rwe pulse=%b want 0", saw_rwe);
        end
        tests_run++;
        if (regs[3] !== 4'b0010) begin
            tests_failed++;
            $display("FAIL abort_regfile: got r3=%b want 0010", regs[3]);
        end
        $display("[TB] reset during EXEC: r3=%b rwe_seen=%b", regs[3], saw_rwe);
    endtask

    task automatic test_back_to_back;
        logic [7:0] q [3];
        int         acc_cyc [3];
        logic [3:0] dws [3];
        int         n;
        int         nw;
        int         cyc;
        logic       rdy;
        q[0] = 8'b11_01_0111;
        q[1] = 8'b00_01_01_01;
        q[2] = 8'b11_10_0011;
        n   = 0;
        nw  = 0;
        cyc = 0;
        instr       = q[0];
        instr_valid = 1'b1;
        for (int c = 0; c < 40 && (n < 3 || nw < 3); c++) begin
            rdy = instr_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy && instr_valid && n < 3) begin
                acc_cyc[n] = cyc;
                n++;
                if (n < 3) instr = q[n];
                else instr_valid = 1'b0;
            end
            if (busy) begin
                tests_run++;
                if (instr_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_ready_busy: got ready=%b at cycle %0d want 0", instr_ready, cyc);
                end
            end
            if (rwe && nw < 3) begin
                dws[nw] = dw;
                $display("[TB] b2b write %0d rw=%b dw=%b", nw, rw, dw);
                nw++;
            end
        end
        instr_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (n != 3 || nw != 3) begin
            tests_failed++;
            $display("FAIL b2b_count: got accepts=%0d writes=%0d want 3 3", n, nw);
        end else begin
            tests_run++;
            if (acc_cyc[1] - acc_cyc[0] != 4 || acc_cyc[2] - acc_cyc[1] != 4) begin
                tests_failed++;
                $display("FAIL b2b_spacing: got gaps %0d %0d want 4 4",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
            tests_run++;
            if (dws[0] !== 4'b0111 || dws[1] !== 4'b1110 || dws[2] !== 4'b0011) begin
                tests_failed++;
                $display("FAIL b2b_results: got %b %b %b want 0111 1110 0011", dws[0], dws[1], dws[2]);
            end
        end
    endtask

    task automatic test_and_toggle;
        exec_instr(8'b11_01_1100, 1'b0);
        exec_instr(8'b11_10_1010, 1'b0);
        exec_instr(8'b10_00_01_10, 1'b1);
        tests_run++;
        if ({wb_seen, wb_rw, wb_dw, wb_carry, wb_zero} !== {1'b1, 2'b00, 4'b1000, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL and_result: got seen=%b rw=%b dw=%b c=%b z=%b want 1 00 1000 0 0",
                     wb_seen, wb_rw, wb_dw, wb_carry, wb_zero);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || regs[0] !== 4'b1000) begin
            tests_failed++;
            $display("FAIL and_no_queue: got busy=%b r0=%b want busy=0 r0=1000", busy, regs[0]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 4; i++) regs[i] = 4'b0000;
        rst         = 1'b1;
        instr       = 8'h00;
        instr_valid = 1'b0;
        test_reset();
        test_ldi();
        test_add_carry();
        test_sub();
        test_reset_in_exec();
        test_back_to_back();
        test_and_toggle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
